// File: rtl/vote_session_if.sv
// Voter/session handshake bundle between the voter input logic and vote_session_fsm.
// master drives commands and votes; slave (the controller) drives status and tallies.
interface vote_session_if #(
    parameter int unsigned N = 5
) ();
    localparam int unsigned CW = $clog2(N + 1);

    logic          start;
    logic          close;
    logic [N-1:0]  vote_yes;
    logic [N-1:0]  vote_no;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] yes_cnt;
    logic [CW-1:0] no_cnt;
    logic [N-1:0]  voted;
    logic          timed_out;

    modport master (
        output start, close, vote_yes, vote_no,
        input  busy, done, pass, yes_cnt, no_cnt, voted, timed_out
    );

    modport slave (
        input  start, close, vote_yes, vote_no,
        output busy, done, pass, yes_cnt, no_cnt, voted, timed_out
    );
endinterface

// File: rtl/vote_session_fsm.sv
// N-voter threshold voting session controller with registered result and tallies.
// Optional session timeout compiled in with `define VOTE_TIMEOUT_EN.
module vote_session_fsm #(
    parameter int unsigned N       = 5,
    parameter int unsigned THRESH  = N / 2 + 1,
    parameter int unsigned TIMEOUT = 1000
) (
    input logic           clk,
    input logic           rst,
    vote_session_if.slave bus
);
    localparam int unsigned CW = $clog2(N + 1);

    if (N < 2 || N > 16 || THRESH < 1 || THRESH > N || TIMEOUT < 2) begin : gen_param_check
        $error("vote_session_fsm: parameter out of range");
    end

    typedef enum logic [1:0] {StIdle, StOpen, StResult} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  yes_mask_q, yes_mask_d;
    logic [N-1:0]  no_mask_q, no_mask_d;
    logic [N-1:0]  voted_q, voted_d;
    logic [CW-1:0] yes_cnt_q, yes_cnt_d;
    logic [CW-1:0] no_cnt_q, no_cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          timed_out_q, timed_out_d;
    logic          all_voted;
    logic          timeout_hit;

`ifdef VOTE_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tmr_q, tmr_d;
    assign timeout_hit = (tmr_q == TW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        state_d     = state_q;
        yes_mask_d  = yes_mask_q;
        no_mask_d   = no_mask_q;
        voted_d     = voted_q;
        yes_cnt_d   = yes_cnt_q;
        no_cnt_d    = no_cnt_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timed_out_d = timed_out_q;
        all_voted   = 1'b0;
`ifdef VOTE_TIMEOUT_EN
        tmr_d       = tmr_q;
`endif

        unique case (state_q)
            StIdle, StResult: begin
                if (bus.start) begin
                    state_d     = StOpen;
                    yes_mask_d  = '0;
                    no_mask_d   = '0;
                    voted_d     = '0;
                    yes_cnt_d   = '0;
                    no_cnt_d    = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    timed_out_d = 1'b0;
`ifdef VOTE_TIMEOUT_EN
                    tmr_d       = '0;
`endif
                end
            end
            StOpen: begin
                // Simultaneous yes+no is an invalid press; the voter stays unvoted.
                for (int i = 0; i < N; i++) begin
                    if (!voted_q[i]) begin
                        if (bus.vote_yes[i] && !bus.vote_no[i]) begin
                            yes_mask_d[i] = 1'b1;
                        end else if (bus.vote_no[i] && !bus.vote_yes[i]) begin
                            no_mask_d[i] = 1'b1;
                        end
                    end
                end
                voted_d   = yes_mask_d | no_mask_d;
                yes_cnt_d = popcount(yes_mask_d);
                no_cnt_d  = popcount(no_mask_d);
                all_voted = &voted_d;

                if (bus.close || all_voted || timeout_hit) begin
                    state_d     = StResult;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = (32'(yes_cnt_d) >= THRESH);
                    timed_out_d = timeout_hit && !bus.close && !all_voted;
                end
`ifdef VOTE_TIMEOUT_EN
                else begin
                    tmr_d = tmr_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            yes_mask_q  <= '0;
            no_mask_q   <= '0;
            voted_q     <= '0;
            yes_cnt_q   <= '0;
            no_cnt_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
`ifdef VOTE_TIMEOUT_EN
            tmr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            yes_mask_q  <= yes_mask_d;
            no_mask_q   <= no_mask_d;
            voted_q     <= voted_d;
            yes_cnt_q   <= yes_cnt_d;
            no_cnt_q    <= no_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timed_out_q <= timed_out_d;
`ifdef VOTE_TIMEOUT_EN
            tmr_q       <= tmr_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.yes_cnt   = yes_cnt_q;
    assign bus.no_cnt    = no_cnt_q;
    assign bus.voted     = voted_q;
    assign bus.timed_out = timed_out_q;
endmodule

// File: doc/vote_session_fsm.md
# vote_session_fsm

Registered, parametrised N-voter threshold voting controller: the sequential successor to the combinational 3-of-5 majority gate in the digital-logic lab set. It opens a voting session on command, lets each voter cast exactly one yes/no vote, closes on command, when everyone has voted, or on optional timeout, then holds a registered pass/fail result with tallies until the next session. It sits between debounced voter pushbutton inputs and the display/LED driver logic.

## Interface
- N, 5, number of voters (2..16)
- THRESH, N/2+1, minimum yes count for pass (1..N)
- TIMEOUT, 1000, session length in cycles when timeout is compiled in (>=2)
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: open a new session (honoured in IDLE or RESULT only)
- close  in  1  pulse: end the session (honoured in OPEN only)
- vote_yes  in  N  per-voter yes request, sampled each cycle
- vote_no  in  N  per-voter no request, sampled each cycle
- busy  out  1  session open (state OPEN)
- done  out  1  result valid (state RESULT)
- pass  out  1  yes_cnt >= THRESH, valid while done
- yes_cnt  out  $clog2(N+1)  yes tally
- no_cnt  out  $clog2(N+1)  no tally
- voted  out  N  per-voter "has voted" mask
- timed_out  out  1  session ended by timeout, valid while done

## Operation
- States: IDLE, OPEN, RESULT. Reset -> IDLE.
- IDLE --start--> OPEN. RESULT --start--> OPEN. start in OPEN ignored.
- Entering OPEN: yes_mask, no_mask, voted, yes_cnt, no_cnt, pass, timed_out, timeout counter all cleared in the same edge.
- In OPEN, per voter i with voted[i]=0: vote_yes[i]&~vote_no[i] records yes; vote_no[i]&~vote_yes[i] records no; both high is invalid and ignored (voter stays unvoted). Voters with voted[i]=1 are locked; further requests ignored.
- yes_cnt/no_cnt = registered popcounts of yes_mask/no_mask; yes_cnt+no_cnt = popcount(voted) always.
- OPEN -> RESULT when any of: close=1; all N voted after this cycle's sampling; timeout expiry (macro). Votes sampled in the closing cycle count.
- On transition to RESULT: pass <= (final yes count >= THRESH); timed_out <= 1 only if timeout was the sole cause (close or all-voted in same cycle take precedence, timed_out=0).
- RESULT holds all outputs stable until start or rst. close and votes ignored in IDLE and RESULT.
- rst at any time, including mid-session: all state and outputs to reset values next edge; session discarded.

## Timing
- Reset values: busy=0, done=0, pass=0, yes_cnt=0, no_cnt=0, voted=0, timed_out=0.
- start at edge t -> busy=1 from t+1, tallies zero at t+1.
- Vote sampled at edge t -> voted[i], tally visible at t+1.
- Closing condition at edge t -> busy=0, done=1, pass valid at t+1.
- start in RESULT at t -> done=0, busy=1, tallies cleared at t+1.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- VOTE_TIMEOUT_EN defined: a cycle counter ($clog2(TIMEOUT) bits) runs in OPEN from 0; when it reaches TIMEOUT-1 the FSM closes on that edge (session lasts exactly TIMEOUT cycles in OPEN), setting timed_out=1 unless close/all-voted coincides.
- Undefined: no counter synthesised, session closes only by close or all-voted; timed_out constant 0; TIMEOUT unused.

## Test plan
- N=5, THRESH=3: start; voters 0,1,2 yes, 3 no in separate cycles; close -> done=1 one cycle later, pass=1, yes_cnt=3, no_cnt=1, voted=5'b01111.
- All five vote in one cycle (yes on 0,1; no on 2,3,4), no close -> done=1 next cycle, pass=0, yes_cnt=2, no_cnt=3, voted=5'b11111.
- Voter 0 asserts yes then no on later cycle, voter 1 asserts both together then yes alone -> voter 0 counted yes once, voter 1 counted yes only from the clean cycle; yes_cnt=2.
- rst pulsed mid-session after 2 votes -> next cycle all outputs 0, state IDLE; subsequent close ignored, done stays 0.
- With VOTE_TIMEOUT_EN, TIMEOUT=8: start, one yes vote, no close -> done=1 exactly 8 cycles after busy rose, timed_out=1, pass=0; rerun with close on the expiry edge -> timed_out=0.
- start issued in RESULT -> next cycle done=0, busy=1, yes_cnt=no_cnt=0, voted=0; start during OPEN has no effect on tallies.
